spwtcr_link_fsm: RTL

SPWTCR_LINK_FSM -- requirements
Module: spwtcr_link_fsm

---
 rtl/spwtcr_link_fsm.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spwtcr_link_fsm.sv
//-----------------------------------------------------------------------------
// spwtcr_link_fsm
//
// SpaceWire-style link initialisation state machine. It sequences the link
// through ErrorReset -> ErrorWait -> Ready -> Started -> Connecting -> Run.
// It enables the receiver and transmitter as each state requires. Any
// receive error, out-of-order character, credit error or dwell timeout drops
// the link back to ErrorReset.
//
// Parameters
//   TIMER_WIDTH  width of the dwell timer
//   T_6U4        ErrorReset dwell in cycles
//   T_12U8       ErrorWait dwell and Started/Connecting timeout in cycles
//
// Ports
//   CLOCK          system clock
//   RESET          synchronous active-high reset
//   link_start     host: start the link
//   link_disable   host: hold the link down / drop it from Run
//   auto_start     host: start once a NULL has been received
//   rx_got_bit     receiver saw a bit (pulse)
//   rx_got_null    receiver saw a NULL (pulse)
//   rx_got_fct     receiver saw an FCT (pulse)
//   rx_got_nchar   receiver saw an N-char (pulse)
//   rx_got_tc      receiver saw a time-code (pulse)
//   rx_disconnect  receive disconnect timeout (level)
//   rx_err_par     receive parity error (pulse)
//   rx_err_esc     receive escape error (pulse)
//   tx_credit_err  transmit credit error (pulse)
//   rx_enable      receiver / disconnect timeout enable
//   tx_enable      transmitter enable (sends NULLs)
//   tx_send_fct    transmitter may send FCTs
//   link_state     0 ErrorReset, 1 ErrorWait, 2 Ready, 3 Started,
//                  4 Connecting, 5 Run
//   link_running   high in Run only
//   link_error     one-cycle pulse on error-caused entry to ErrorReset
//-----------------------------------------------------------------------------
module spwtcr_link_fsm #(
    parameter int unsigned            TIMER_WIDTH = 12,
    parameter logic [TIMER_WIDTH-1:0] T_6U4       = 12'd1280,
    parameter logic [TIMER_WIDTH-1:0] T_12U8      = 12'd2560
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       link_start,
    input  logic       link_disable,
    input  logic       auto_start,
    input  logic       rx_got_bit,
    input  logic       rx_got_null,
    input  logic       rx_got_fct,
    input  logic       rx_got_nchar,
    input  logic       rx_got_tc,
    input  logic       rx_disconnect,
    input  logic       rx_err_par,
    input  logic       rx_err_esc,
    input  logic       tx_credit_err,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       tx_send_fct,
    output logic [2:0] link_state,
    output logic       link_running,
    output logic       link_error
);

    localparam logic [2:0] ST_ERESET     = 3'd0;
    localparam logic [2:0] ST_EWAIT      = 3'd1;
    localparam logic [2:0] ST_READY      = 3'd2;
    localparam logic [2:0] ST_STARTED    = 3'd3;
    localparam logic [2:0] ST_CONNECTING = 3'd4;
    localparam logic [2:0] ST_RUN        = 3'd5;

    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = {TIMER_WIDTH{1'b1}};
    // A limit T is reached on the T-th cycle in the state, i.e. timer == T-1.
    localparam logic [TIMER_WIDTH-1:0] LIM_6U4    = T_6U4 - TIMER_ONE;
    localparam logic [TIMER_WIDTH-1:0] LIM_12U8   = T_12U8 - TIMER_ONE;

    logic [2:0]             state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   got_bit_q, got_bit_d;
    logic                   got_null_q, got_null_d;
    logic                   link_error_q, link_error_d;

    // Event qualification shared by several states.
    logic err;          // error that is reported through link_error
    logic got_null_any; // NULL seen earlier in this attempt or right now
    logic bad_order;    // character that may not arrive before Run

    // A disconnect timeout is meaningless until the receiver has ever seen a
    // bit, otherwise an idle line would be flagged straight after enable.
    assign err          = rx_err_par | rx_err_esc |
                          (rx_disconnect & (got_bit_q | rx_got_bit));
    assign got_null_any = got_null_q | rx_got_null;
    assign bad_order    = rx_got_nchar | rx_got_tc;

    //-------------------------------------------------------------------------
    // State register, dwell timer, receive latches and error pulse
    //-------------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= ST_ERESET;
            timer_q      <= '0;
            got_bit_q    <= 1'b0;
            got_null_q   <= 1'b0;
            link_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            got_bit_q    <= got_bit_d;
            got_null_q   <= got_null_d;
            link_error_q <= link_error_d;
        end
    end

    //-------------------------------------------------------------------------
    // Next-state logic
    //-------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        link_error_d = 1'b0;

        // Reset-causing conditions are tested before any advancing condition
        // in every state, so they always win a same-cycle race.
        case (state_q)
            ST_ERESET: begin
                if (timer_q == LIM_6U4) begin
                    state_d = ST_EWAIT;
                end
            end
            ST_EWAIT: begin
                if (err) begin
                    state_d      = ST_ERESET;
                    link_error_d = 1'b1;
                end else if (rx_got_fct | bad_order) begin
                    state_d = ST_ERESET;
                end else if (timer_q == LIM_12U8) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (err) begin
                    state_d      = ST_ERESET;
                    link_error_d = 1'b1;
                end else if (rx_got_fct | bad_order) begin
                    state_d = ST_ERESET;
                end else if (!link_disable &&
                             (link_start || (auto_start && got_null_any))) begin
                    state_d = ST_STARTED;
                end
            end
            ST_STARTED: begin
                if (err) begin
                    state_d      = ST_ERESET;
                    link_error_d = 1'b1;
                end else if (rx_got_fct | bad_order | (timer_q == LIM_12U8)) begin
                    state_d = ST_ERESET;
                end else if (got_null_any) begin
                    state_d = ST_CONNECTING;
                end
            end
            ST_CONNECTING: begin
                // FCT is the expected handshake here, not an order violation.
                if (err) begin
                    state_d      = ST_ERESET;
                    link_error_d = 1'b1;
                end else if (bad_order | (timer_q == LIM_12U8)) begin
                    state_d = ST_ERESET;
                end else if (rx_got_fct) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (err | tx_credit_err) begin
                    state_d      = ST_ERESET;
                    link_error_d = 1'b1;
                end else if (link_disable) begin
                    state_d = ST_ERESET;
                end
            end
            default: begin
                state_d = ST_ERESET;
            end
        endcase

        // Timer restarts on every state change. Ready and Run have no limit,
        // so it saturates there instead of wrapping.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TIMER_ONE;
        end

        // Receive history belongs to one connection attempt only.
        if (state_q == ST_ERESET) begin
            got_bit_d  = 1'b0;
            got_null_d = 1'b0;
        end else begin
            got_bit_d  = got_bit_q | rx_got_bit;
            got_null_d = got_null_q | rx_got_null;
        end
    end

    //-------------------------------------------------------------------------
    // Output decode (from registered state only)
    //-------------------------------------------------------------------------
    always_comb begin
        rx_enable    = 1'b0;
        tx_enable    = 1'b0;
        tx_send_fct  = 1'b0;
        link_running = 1'b0;
        case (state_q)
            ST_EWAIT, ST_READY: begin
                rx_enable = 1'b1;
            end
            ST_STARTED: begin
                rx_enable = 1'b1;
                tx_enable = 1'b1;
            end
            ST_CONNECTING: begin
                rx_enable   = 1'b1;
                tx_enable   = 1'b1;
                tx_send_fct = 1'b1;
            end
            ST_RUN: begin
                rx_enable    = 1'b1;
                tx_enable    = 1'b1;
                tx_send_fct  = 1'b1;
                link_running = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign link_state = state_q;
    assign link_error = link_error_q;

endmodule
